// File: rtl/multicycle_alu.sv
// Handshaked ALU: single-cycle add/sub/logic/shift ops plus iterative
// shift-add multiply and restoring unsigned divide (WIDTH cycles each).
module multicycle_alu #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned H   = WIDTH / 2;
   localparam int unsigned CW  = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_ORR  = 4'd3;
   localparam logic [3:0] OP_NOT  = 4'd4;
   localparam logic [3:0] OP_TCP  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_LHI  = 4'd8;
   localparam logic [3:0] OP_PASS = 4'd9;
   localparam logic [3:0] OP_ADI  = 4'd10;
   localparam logic [3:0] OP_SRAV = 4'd11;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] opd;
   logic [1:0]       iter_op;

   logic             accept;
   logic             step;
   logic             is_iter;
   logic [WIDTH-1:0] alu_res;
   logic             alu_v;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] hi_next;
   logic [WIDTH-1:0] lo_next;
   logic [WIDTH-1:0] fin_res;

   assign is_iter = op[3] & op[2];

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = is_iter ? BUSY : DONE;
         BUSY: if (cnt == CW'(1)) state_next = DONE;
         DONE: begin
            if (out_ready) begin
               if (accept) state_next = is_iter ? BUSY : DONE;
               else        state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake / control outputs
   always_comb begin
      in_ready = 1'b0;
      step     = 1'b0;
      case (state)
         IDLE:    in_ready = 1'b1;
         BUSY:    step     = 1'b1;
         DONE:    in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
      accept = in_valid & in_ready;
   end

   // Single-cycle operations
   always_comb begin
      alu_res = '0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = a + b;
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = a - b;
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_ORR:  alu_res = a | b;
         OP_NOT:  alu_res = ~a;
         OP_TCP:  alu_res = WIDTH'(0) - a;
         OP_SHL:  alu_res = {a[WIDTH-2:0], 1'b0};
         OP_SHR:  alu_res = {a[WIDTH-1], a[WIDTH-1:1]};
         OP_LHI:  alu_res = {b[H-1:0], {H{1'b0}}};
         OP_PASS: alu_res = a;
         OP_ADI:  alu_res = a + {{(WIDTH-H){b[H-1]}}, b[H-1:0]};
         OP_SRAV: alu_res = $unsigned($signed(a) >>> b[SHW-1:0]);
         default: alu_res = '0;
      endcase
   end

   // One iteration: hi:lo is the product accumulator (mul) or remainder:quotient (div)
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
      div_shift = {hi, lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opd};
      hi_next   = hi;
      lo_next   = lo;
      if (!iter_op[1]) begin
         hi_next = mul_sum[WIDTH:1];
         lo_next = {mul_sum[0], lo[WIDTH-1:1]};
      end else if (!div_diff[WIDTH]) begin
         hi_next = div_diff[WIDTH-1:0];
         lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
         hi_next = div_shift[WIDTH-1:0];
         lo_next = {lo[WIDTH-2:0], 1'b0};
      end
      fin_res = iter_op[0] ? hi_next : lo_next;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         hi        <= '0;
         lo        <= '0;
         opd       <= '0;
         iter_op   <= '0;
         result    <= '0;
         flag_z    <= 1'b0;
         flag_n    <= 1'b0;
         flag_v    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state_next == DONE);
         if (accept) begin
            if (is_iter) begin
               cnt     <= CW'(WIDTH);
               hi      <= '0;
               lo      <= op[1] ? a : b;
               opd     <= op[1] ? b : a;
               iter_op <= op[1:0];
            end else begin
               result <= alu_res;
               flag_z <= (alu_res == '0);
               flag_n <= alu_res[WIDTH-1];
               flag_v <= alu_v;
            end
         end else if (step) begin
            cnt <= CW'(cnt - CW'(1));
            hi  <= hi_next;
            lo  <= lo_next;
            if (cnt == CW'(1)) begin
               result <= fin_res;
               flag_z <= (fin_res == '0);
               flag_n <= fin_res[WIDTH-1];
               flag_v <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: directed vectors, back-pressure,
// reset abort and randomized traffic against an arithmetic reference model.
module tb_multicycle_alu;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset_n, in_valid, in_ready, out_valid, out_ready;
   logic         flag_z, flag_n, flag_v;
   logic [3:0]   op;
   logic [W-1:0] a, b, result;

   typedef struct {
      logic [W-1:0] res;
      logic         z, n, v;
      int           lat;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   rdy_mode = 0;
   bit   fresh = 1'b1;
   bit   held = 1'b0;
   logic [W+2:0] hold_val;

   multicycle_alu #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h @%0t", name, got, want, $time);
      end
   endtask

   // Reference model: plain integer arithmetic on the operation definitions
   function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t  e;
      int    sx = int'($signed(x));
      int    sy = int'($signed(y));
      int    r = 0;
      longint p = longint'(x) * longint'(y);
      bit    v = 1'b0;
      case (o)
         4'd0:  begin r = sx + sy; v = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1))); end
         4'd1:  begin r = sx - sy; v = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1))); end
         4'd2:  r = int'(x & y);
         4'd3:  r = int'(x | y);
         4'd4:  r = ~sx;
         4'd5:  r = -sx;
         4'd6:  r = sx * 2;
         4'd7:  r = sx >>> 1;
         4'd8:  r = int'(y[7:0]) * 256;
         4'd9:  r = sx;
         4'd10: r = sx + int'($signed(y[7:0]));
         4'd11: r = sx >>> int'(y & 16'h000F);
         4'd12: r = int'(p % 65536);
         4'd13: r = int'(p / 65536);
         4'd14: r = (y == 0) ? 32'hFFFF : int'(x / y);
         default: r = (y == 0) ? int'(x) : int'(x % y);
      endcase
      e.res = r[W-1:0];
      e.z   = (e.res == 0);
      e.n   = e.res[W-1];
      e.v   = v;
      e.lat = (o >= 4'd12) ? W : 0;
      e.acc = 0;
      return e;
   endfunction

   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit use_k, input logic [W-1:0] kr, input logic [2:0] kf,
                        output int waits);
      exp_t e;
      op = o; a = x; b = y; in_valid = 1'b1; waits = 0;
      @(negedge clk);
      while (!in_ready && waits < 300) begin waits++; @(negedge clk); end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL accept_timeout op=%0d waited=%0d cycles, required accept", o, waits);
      end else begin
         e = model(o, x, y);
         if (use_k) begin e.res = kr; {e.z, e.n, e.v} = kf; end
         e.acc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 1000 && sb.size() > 0; i++) @(posedge clk);
      check(name, 32'(sb.size()), 32'd0);
      #1;
   endtask

   // Monitor: latency, hold stability, handshake rule and scoreboard compare
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         check("reset_outputs", {out_valid, flag_z, flag_n, flag_v, 12'h0, result}, 32'h0);
         fresh = 1'b1; held = 1'b0;
      end else if (out_valid) begin
         check("in_ready_in_done", 32'(in_ready), 32'(out_ready));
         if (held) check("hold_stable", 32'({result, flag_z, flag_n, flag_v}), 32'(hold_val));
         if (fresh) begin
            if (sb.size() == 0) check("spurious_output", 32'(out_valid), 32'd0);
            else check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
            fresh = 1'b0;
         end
         if (out_ready) begin
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("result_flags", 32'({result, flag_z, flag_n, flag_v}), 32'({e.res, e.z, e.n, e.v}));
            end
            fresh = 1'b1; held = 1'b0;
         end else begin
            held = 1'b1;
            hold_val = {result, flag_z, flag_n, flag_v};
         end
      end else begin
         if (held) check("hold_dropped", 32'(out_valid), 32'd1);
         held = 1'b0; fresh = 1'b1;
      end
   end

   initial begin
      int w;
      logic [3:0]   o;
      logic [W-1:0] x, y;
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_reset", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Directed vectors with fixed expected values
      issue(4'd0,  16'h7FFF, 16'h0001, 1, 16'h8000, 3'b011, w);
      issue(4'd1,  16'h0005, 16'h0005, 1, 16'h0000, 3'b100, w);
      issue(4'd12, 16'h0123, 16'h0456, 1, 16'hEDC2, 3'b010, w);
      issue(4'd13, 16'h0123, 16'h0456, 1, 16'h0004, 3'b000, w);
      issue(4'd14, 16'h1234, 16'h0010, 1, 16'h0123, 3'b000, w);
      issue(4'd15, 16'h1234, 16'h0010, 1, 16'h0004, 3'b000, w);
      issue(4'd14, 16'h1234, 16'h0000, 1, 16'hFFFF, 3'b010, w);
      issue(4'd15, 16'h1234, 16'h0000, 1, 16'h1234, 3'b000, w);
      issue(4'd11, 16'h8000, 16'h0013, 1, 16'hF000, 3'b010, w);
      issue(4'd10, 16'h0010, 16'h00FF, 1, 16'h000F, 3'b000, w);
      issue(4'd8,  16'h5A5A, 16'h12AB, 1, 16'hAB00, 3'b010, w);
      drain("drain_directed");

      // Back-pressure, then same-edge handoff and a back-to-back burst
      out_ready = 1'b0;
      issue(4'd0, 16'h7FFF, 16'h0001, 1, 16'h8000, 3'b011, w);
      repeat (5) @(posedge clk);
      #1 out_ready = 1'b1;
      issue(4'd1, 16'h0005, 16'h0005, 1, 16'h0000, 3'b100, w);
      check("handoff_waits", 32'(w), 32'd0);
      for (int i = 0; i < 8; i++) begin
         issue(4'($urandom_range(0, 11)), W'($urandom), W'($urandom), 0, '0, '0, w);
         check("burst_waits", 32'(w), 32'd0);
      end
      drain("drain_burst");

      // Reset abort mid-divide
      issue(4'd14, 16'h1234, 16'h0010, 0, '0, '0, w);
      repeat (4) @(posedge clk);
      #1 reset_n = 1'b0;
      sb.delete();
      repeat (5) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("abort_state", {in_ready, out_valid, 14'h0, result}, 32'h8000_0000);
      @(posedge clk); #1;
      issue(4'd0, 16'h0002, 16'h0003, 1, 16'h0005, 3'b000, w);
      drain("drain_after_reset");

      // Randomized traffic with random back-pressure
      rdy_mode = 1;
      for (int i = 0; i < 300; i++) begin
         o = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 7))
            0: x = 16'h0000; 1: x = 16'hFFFF; 2: x = 16'h8000; 3: x = 16'h7FFF;
            default: x = W'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0: y = 16'h0000; 1: y = 16'hFFFF; 2: y = 16'h8000; 3: y = 16'h0001;
            default: y = W'($urandom);
         endcase
         issue(o, x, y, 0, '0, '0, w);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      rdy_mode = 0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      drain("drain_random");

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
